// File: rtl/apb2axi_issue_sched_if.sv
// ---------------------------------------------------------------------------
// apb2axi_issue_sched_if
// Purpose : Groups the issue-stage offer/accept handshake of the APB-to-AXI
//           issue scheduler, together with the issued-tag notification that
//           is sent back to the request directory.
// Ports   : issue_valid    - scheduler offers issue_tag to the issue stage
//           issue_ready    - issue stage accepts the current offer
//           issue_tag      - offered directory tag
//           issue_is_write - direction of the offered tag (1 = write)
//           issued_pulse   - one-cycle pulse after a completed handshake
//           issued_tag     - tag that was accepted
// Modports: master (scheduler side), slave (issue stage / directory side)
// ---------------------------------------------------------------------------
interface apb2axi_issue_sched_if #(
  parameter int NUM_TAGS = 16,
  parameter int TAG_W    = $clog2(NUM_TAGS)
);
  logic             issue_valid;
  logic             issue_ready;
  logic [TAG_W-1:0] issue_tag;
  logic             issue_is_write;
  logic             issued_pulse;
  logic [TAG_W-1:0] issued_tag;

  modport master (
    output issue_valid,
    output issue_tag,
    output issue_is_write,
    output issued_pulse,
    output issued_tag,
    input  issue_ready
  );

  modport slave (
    input  issue_valid,
    input  issue_tag,
    input  issue_is_write,
    input  issued_pulse,
    input  issued_tag,
    output issue_ready
  );
endinterface

// File: rtl/apb2axi_issue_sched.sv
// ---------------------------------------------------------------------------
// apb2axi_issue_sched
// Purpose : Picks one PENDING directory entry per grant, round-robin, subject
//           to per-direction outstanding limits, offers it to the AXI AR/AW
//           issue stage with valid/ready, and counts reads and writes in
//           flight until the response handler retires them.
// Ports   : pclk          - clock
//           preset        - synchronous active-high reset
//           sched_en      - allows new grants (an open offer still completes)
//           pend_mask     - PENDING bit per directory entry
//           pend_is_write - direction per directory entry (1 = write)
//           bus           - issue handshake interface (master modport)
//           rd_retire     - one read completed
//           wr_retire     - one write completed
//           rd_outst      - reads issued and not yet retired
//           wr_outst      - writes issued and not yet retired
//           cnt_err       - sticky: retire seen while its counter was 0
//           busy          - offer open or any transaction outstanding
// Option  : define APB2AXI_SCHED_WR_PRIO_EN to give eligible writes strict
//           priority over reads (round-robin within the writes). Without it a
//           single round-robin spans both directions.
// ---------------------------------------------------------------------------
module apb2axi_issue_sched #(
  parameter int NUM_TAGS     = 16,
  parameter int MAX_RD_OUTST = 4,
  parameter int MAX_WR_OUTST = 4
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                sched_en,
  input  logic [NUM_TAGS-1:0] pend_mask,
  input  logic [NUM_TAGS-1:0] pend_is_write,
  apb2axi_issue_sched_if.master bus,
  input  logic                rd_retire,
  input  logic                wr_retire,
  output logic [3:0]          rd_outst,
  output logic [3:0]          wr_outst,
  output logic                cnt_err,
  output logic                busy
);

  localparam int TAG_W = $clog2(NUM_TAGS);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } state_e;

  // Round-robin pick: returns {found, tag}. The scan runs from the far end
  // back toward ptr so the last hit recorded is the first one upward of ptr.
  function automatic logic [TAG_W:0] rr_pick(input logic [NUM_TAGS-1:0] req,
                                             input logic [TAG_W-1:0]    ptr);
    logic [TAG_W:0]   res;
    logic [TAG_W-1:0] tidx;
    res = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      tidx = TAG_W'((int'(ptr) + i) % NUM_TAGS);
      if (req[tidx]) begin
        res = {1'b1, tidx};
      end
    end
    return res;
  endfunction

  // One-hot decode of a tag.
  function automatic logic [NUM_TAGS-1:0] tag_onehot(input logic [TAG_W-1:0] tag);
    logic [NUM_TAGS-1:0] m;
    m      = '0;
    m[tag] = 1'b1;
    return m;
  endfunction

  // Outstanding counter update: returns {err, next_count}. Issue and retire
  // together cancel; a retire against an empty counter saturates and flags.
  function automatic logic [4:0] cnt_next(input logic [3:0] cnt,
                                          input logic       inc,
                                          input logic       dec);
    logic [4:0] res;
    case ({inc, dec})
      2'b11:   res = {(cnt == 4'd0), cnt};
      2'b10:   res = {1'b0, cnt + 4'd1};
      2'b01:   res = (cnt == 4'd0) ? {1'b1, 4'd0} : {1'b0, cnt - 4'd1};
      default: res = {1'b0, cnt};
    endcase
    return res;
  endfunction

  state_e              state_q, state_d;
  logic                issue_valid_q, issue_valid_d;
  logic [TAG_W-1:0]    issue_tag_q, issue_tag_d;
  logic                issue_is_write_q, issue_is_write_d;
  logic                issued_pulse_q, issued_pulse_d;
  logic [TAG_W-1:0]    issued_tag_q, issued_tag_d;
  logic [TAG_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_TAGS-1:0] last_tag_mask_q, last_tag_mask_d;
  logic [3:0]          rd_outst_q, rd_outst_d;
  logic [3:0]          wr_outst_q, wr_outst_d;
  logic                cnt_err_q, cnt_err_d;
  logic                busy_q, busy_d;

  logic [NUM_TAGS-1:0] elig_s;
  logic [NUM_TAGS-1:0] cand_s;
  logic [TAG_W:0]      pick_s;
  logic                rd_inc_s, wr_inc_s;
  logic [4:0]          rd_upd_s, wr_upd_s;

  // Eligibility per tag and the candidate set handed to the round-robin.
  always_comb begin
    elig_s = '0;
    cand_s = '0;
    for (int t = 0; t < NUM_TAGS; t++) begin
      if (pend_is_write[t]) begin
        elig_s[t] = pend_mask[t] & ~last_tag_mask_q[t] & (wr_outst_q < 4'(MAX_WR_OUTST));
      end else begin
        elig_s[t] = pend_mask[t] & ~last_tag_mask_q[t] & (rd_outst_q < 4'(MAX_RD_OUTST));
      end
    end
`ifdef APB2AXI_SCHED_WR_PRIO_EN
    if (|(elig_s & pend_is_write)) begin
      cand_s = elig_s & pend_is_write;
    end else begin
      cand_s = elig_s;
    end
`else
    cand_s = elig_s;
`endif
    pick_s = rr_pick(cand_s, rr_ptr_q);
  end

  // Offer FSM next-state and registered-output logic.
  always_comb begin
    state_d          = state_q;
    issue_valid_d    = issue_valid_q;
    issue_tag_d      = issue_tag_q;
    issue_is_write_d = issue_is_write_q;
    issued_pulse_d   = 1'b0;
    issued_tag_d     = issued_tag_q;
    rr_ptr_d         = rr_ptr_q;
    last_tag_mask_d  = '0;
    rd_inc_s         = 1'b0;
    wr_inc_s         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sched_en && pick_s[TAG_W]) begin
          state_d          = S_OFFER;
          issue_valid_d    = 1'b1;
          issue_tag_d      = pick_s[TAG_W-1:0];
          issue_is_write_d = pend_is_write[pick_s[TAG_W-1:0]];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OFFER: begin
        // The offer is frozen here; pend_mask and sched_en are ignored.
        if (bus.issue_ready) begin
          state_d         = S_IDLE;
          issue_valid_d   = 1'b0;
          issued_pulse_d  = 1'b1;
          issued_tag_d    = issue_tag_q;
          rr_ptr_d        = (issue_tag_q == TAG_W'(NUM_TAGS - 1)) ? '0 : issue_tag_q + TAG_W'(1);
          // Hides the accepted tag while the directory still shows it PENDING.
          last_tag_mask_d = tag_onehot(issue_tag_q);
          rd_inc_s        = ~issue_is_write_q;
          wr_inc_s        = issue_is_write_q;
        end else begin
          state_d = S_OFFER;
        end
      end
      default: begin
        state_d       = S_IDLE;
        issue_valid_d = 1'b0;
      end
    endcase
  end

  // Outstanding counters, sticky error flag and busy indication.
  always_comb begin
    rd_upd_s   = cnt_next(rd_outst_q, rd_inc_s, rd_retire);
    wr_upd_s   = cnt_next(wr_outst_q, wr_inc_s, wr_retire);
    rd_outst_d = rd_upd_s[3:0];
    wr_outst_d = wr_upd_s[3:0];
    cnt_err_d  = cnt_err_q | rd_upd_s[4] | wr_upd_s[4];
    // Computed from next-state values so the flop matches the current state.
    busy_d     = (state_d != S_IDLE) || (rd_outst_d != 4'd0) || (wr_outst_d != 4'd0);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q          <= S_IDLE;
      issue_valid_q    <= 1'b0;
      issue_tag_q      <= '0;
      issue_is_write_q <= 1'b0;
      issued_pulse_q   <= 1'b0;
      issued_tag_q     <= '0;
      rr_ptr_q         <= '0;
      last_tag_mask_q  <= '0;
      rd_outst_q       <= 4'd0;
      wr_outst_q       <= 4'd0;
      cnt_err_q        <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      issue_valid_q    <= issue_valid_d;
      issue_tag_q      <= issue_tag_d;
      issue_is_write_q <= issue_is_write_d;
      issued_pulse_q   <= issued_pulse_d;
      issued_tag_q     <= issued_tag_d;
      rr_ptr_q         <= rr_ptr_d;
      last_tag_mask_q  <= last_tag_mask_d;
      rd_outst_q       <= rd_outst_d;
      wr_outst_q       <= wr_outst_d;
      cnt_err_q        <= cnt_err_d;
      busy_q           <= busy_d;
    end
  end

  assign bus.issue_valid    = issue_valid_q;
  assign bus.issue_tag      = issue_tag_q;
  assign bus.issue_is_write = issue_is_write_q;
  assign bus.issued_pulse   = issued_pulse_q;
  assign bus.issued_tag     = issued_tag_q;
  assign rd_outst           = rd_outst_q;
  assign wr_outst           = wr_outst_q;
  assign cnt_err            = cnt_err_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_apb2axi_issue_sched.sv
// ---------------------------------------------------------------------------
// tb_apb2axi_issue_sched
// Purpose : Directed self-checking bench for apb2axi_issue_sched. Inputs are
//           driven 1 time unit after each rising edge and outputs are sampled
//           at the same point, so each tick() observes the result of exactly
//           one clock edge.
// ---------------------------------------------------------------------------
module tb_apb2axi_issue_sched;

  logic        pclk;
  logic        preset;
  logic        sched_en;
  logic [15:0] pend_mask;
  logic [15:0] pend_is_write;
  logic        rd_retire;
  logic        wr_retire;
  logic [3:0]  rd_outst;
  logic [3:0]  wr_outst;
  logic        cnt_err;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  apb2axi_issue_sched_if #(.NUM_TAGS(16)) bus ();

  apb2axi_issue_sched #(
    .NUM_TAGS    (16),
    .MAX_RD_OUTST(4),
    .MAX_WR_OUTST(4)
  ) dut (
    .pclk         (pclk),
    .preset       (preset),
    .sched_en     (sched_en),
    .pend_mask    (pend_mask),
    .pend_is_write(pend_is_write),
    .bus          (bus.master),
    .rd_retire    (rd_retire),
    .wr_retire    (wr_retire),
    .rd_outst     (rd_outst),
    .wr_outst     (wr_outst),
    .cnt_err      (cnt_err),
    .busy         (busy)
  );

  // Free-running clock.
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    preset           = 1'b1;
    sched_en         = 1'b0;
    pend_mask        = 16'h0000;
    pend_is_write    = 16'h0000;
    rd_retire        = 1'b0;
    wr_retire        = 1'b0;
    bus.issue_ready  = 1'b0;
    tick();
    tick();
    preset = 1'b0;
  endtask

  task automatic test_reset();
    // Reset must win over pending requests and an enabled scheduler.
    preset          = 1'b1;
    sched_en        = 1'b1;
    pend_mask       = 16'hFFFF;
    pend_is_write   = 16'h0000;
    rd_retire       = 1'b0;
    wr_retire       = 1'b0;
    bus.issue_ready = 1'b1;
    tick();
    tick();
    checks++; if (bus.issue_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.issue_valid); end
    checks++; if (bus.issued_pulse !== 1'b0) begin failures++; $display("FAIL rst_pulse got=%b exp=0", bus.issued_pulse); end
    checks++; if (bus.issue_tag !== 4'd0) begin failures++; $display("FAIL rst_tag got=%0d exp=0", bus.issue_tag); end
    checks++; if (rd_outst !== 4'd0 || wr_outst !== 4'd0) begin failures++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", rd_outst, wr_outst); end
    checks++; if (cnt_err !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_err_busy got=%b/%b exp=0/0", cnt_err, busy); end
    preset = 1'b0;
  endtask

  task automatic test_sched_en();
    do_reset();
    pend_mask       = 16'h0001;
    bus.issue_ready = 1'b1;
    sched_en        = 1'b0;
    tick();
    tick();
    checks++; if (bus.issue_valid !== 1'b0) begin failures++; $display("FAIL en_off_valid got=%b exp=0", bus.issue_valid); end
    sched_en = 1'b1;
    tick();
    checks++; if (bus.issue_valid !== 1'b1 || bus.issue_tag !== 4'd0) begin failures++; $display("FAIL en_on_offer got=%b/%0d exp=1/0", bus.issue_valid, bus.issue_tag); end
  endtask

  task automatic test_single_read();
    do_reset();
    pend_mask       = 16'h0004;
    pend_is_write   = 16'h0000;
    sched_en        = 1'b1;
    bus.issue_ready = 1'b1;
    tick();
    checks++; if (bus.issue_valid !== 1'b1 || bus.issue_tag !== 4'd2 || bus.issue_is_write !== 1'b0) begin
      failures++; $display("FAIL single_offer got=%b/%0d/%b exp=1/2/0", bus.issue_valid, bus.issue_tag, bus.issue_is_write);
    end
    checks++; if (bus.issued_pulse !== 1'b0) begin failures++; $display("FAIL single_early_pulse got=%b exp=0", bus.issued_pulse); end
    pend_mask = 16'h0000;
    tick();
    checks++; if (bus.issue_valid !== 1'b0 || bus.issued_pulse !== 1'b1 || bus.issued_tag !== 4'd2) begin
      failures++; $display("FAIL single_pulse got=%b/%b/%0d exp=0/1/2", bus.issue_valid, bus.issued_pulse, bus.issued_tag);
    end
    checks++; if (rd_outst !== 4'd1 || wr_outst !== 4'd0) begin failures++; $display("FAIL single_cnt got=%0d/%0d exp=1/0", rd_outst, wr_outst); end
    checks++; if (dut.rr_ptr_q !== 4'd3) begin failures++; $display("FAIL single_rrptr got=%0d exp=3", dut.rr_ptr_q); end
    tick();
    checks++; if (bus.issued_pulse !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL single_after got=%b/%b exp=0/1", bus.issued_pulse, busy); end
  endtask

  task automatic test_wrap();
    int         n;
    logic [3:0] got [3];
    do_reset();
    pend_mask       = 16'h8001;
    sched_en        = 1'b1;
    bus.issue_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.issued_pulse === 1'b1) begin
        if (n < 3) got[n] = bus.issued_tag;
        n++;
      end
    end
    checks++; if (n != 3) begin failures++; $display("FAIL wrap_count got=%0d exp=3", n); end
    checks++; if (n >= 3 && (got[0] !== 4'd0 || got[1] !== 4'd15 || got[2] !== 4'd0)) begin
      failures++; $display("FAIL wrap_order got=%0d,%0d,%0d exp=0,15,0", got[0], got[1], got[2]);
    end
    pend_mask = 16'h0000;
  endtask

  task automatic test_rd_limit();
    int         n;
    logic [3:0] t;
    do_reset();
    pend_mask       = 16'h001F;
    sched_en        = 1'b1;
    bus.issue_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.issued_pulse === 1'b1) begin
        n++;
        pend_mask[bus.issued_tag] = 1'b0;
      end
    end
    checks++; if (n != 4) begin failures++; $display("FAIL limit_grants got=%0d exp=4", n); end
    checks++; if (rd_outst !== 4'd4 || bus.issue_valid !== 1'b0) begin failures++; $display("FAIL limit_block got=%0d/%b exp=4/0", rd_outst, bus.issue_valid); end
    rd_retire = 1'b1;
    tick();
    rd_retire = 1'b0;
    checks++; if (rd_outst !== 4'd3) begin failures++; $display("FAIL limit_retire got=%0d exp=3", rd_outst); end
    n = 0;
    t = 4'd0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.issued_pulse === 1'b1) begin
        n++;
        t = bus.issued_tag;
        pend_mask[bus.issued_tag] = 1'b0;
      end
    end
    checks++; if (n != 1 || t !== 4'd4) begin failures++; $display("FAIL limit_fifth got=%0d/tag%0d exp=1/tag4", n, t); end
    checks++; if (rd_outst !== 4'd4) begin failures++; $display("FAIL limit_final got=%0d exp=4", rd_outst); end
  endtask

  task automatic test_stall();
    int         n;
    logic [3:0] t;
    do_reset();
    pend_mask       = 16'h0020;
    sched_en        = 1'b1;
    bus.issue_ready = 1'b0;
    tick();
    checks++; if (bus.issue_valid !== 1'b1 || bus.issue_tag !== 4'd5) begin failures++; $display("FAIL stall_offer got=%b/%0d exp=1/5", bus.issue_valid, bus.issue_tag); end
    for (int c = 0; c < 6; c++) begin
      pend_mask = ~pend_mask;
      sched_en  = ~sched_en;
      tick();
      checks++; if (bus.issue_valid !== 1'b1 || bus.issue_tag !== 4'd5 || bus.issued_pulse !== 1'b0) begin
        failures++; $display("FAIL stall_hold cyc=%0d got=%b/%0d/%b exp=1/5/0", c, bus.issue_valid, bus.issue_tag, bus.issued_pulse);
      end
    end
    bus.issue_ready = 1'b1;
    sched_en        = 1'b1;
    pend_mask       = 16'h0000;
    n = 0;
    t = 4'd0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.issued_pulse === 1'b1) begin
        n++;
        t = bus.issued_tag;
      end
    end
    checks++; if (n != 1 || t !== 4'd5) begin failures++; $display("FAIL stall_pulse got=%0d/tag%0d exp=1/tag5", n, t); end
  endtask

  task automatic test_retire_collision();
    do_reset();
    pend_mask       = 16'h0008;
    sched_en        = 1'b1;
    bus.issue_ready = 1'b1;
    tick();
    pend_mask = 16'h0000;
    tick();
    checks++; if (rd_outst !== 4'd1) begin failures++; $display("FAIL coll_pre got=%0d exp=1", rd_outst); end
    pend_mask = 16'h0010;
    tick();
    pend_mask = 16'h0000;
    rd_retire = 1'b1;
    tick();
    rd_retire = 1'b0;
    checks++; if (bus.issued_pulse !== 1'b1 || rd_outst !== 4'd1) begin
      failures++; $display("FAIL coll_same got=%b/%0d exp=1/1", bus.issued_pulse, rd_outst);
    end
    wr_retire = 1'b1;
    tick();
    wr_retire = 1'b0;
    checks++; if (cnt_err !== 1'b1 || wr_outst !== 4'd0) begin failures++; $display("FAIL underflow got=%b/%0d exp=1/0", cnt_err, wr_outst); end
    tick();
    tick();
    checks++; if (cnt_err !== 1'b1 || rd_outst !== 4'd1) begin failures++; $display("FAIL err_sticky got=%b/%0d exp=1/1", cnt_err, rd_outst); end
  endtask

  task automatic test_wr_prio();
    logic [3:0] exp_tag;
    logic       exp_w;
`ifdef APB2AXI_SCHED_WR_PRIO_EN
    exp_tag = 4'd2;
    exp_w   = 1'b1;
`else
    exp_tag = 4'd1;
    exp_w   = 1'b0;
`endif
    do_reset();
    pend_mask       = 16'h0006;
    pend_is_write   = 16'h0004;
    sched_en        = 1'b1;
    bus.issue_ready = 1'b1;
    tick();
    checks++; if (bus.issue_valid !== 1'b1 || bus.issue_tag !== exp_tag || bus.issue_is_write !== exp_w) begin
      failures++; $display("FAIL prio_offer got=%b/%0d/%b exp=1/%0d/%b", bus.issue_valid, bus.issue_tag, bus.issue_is_write, exp_tag, exp_w);
    end
    pend_mask[exp_tag] = 1'b0;
    tick();
    checks++; if (wr_outst !== {3'd0, exp_w} || rd_outst !== {3'd0, ~exp_w}) begin
      failures++; $display("FAIL prio_cnt got=%0d/%0d exp=%0d/%0d", rd_outst, wr_outst, ~exp_w, exp_w);
    end
    pend_mask = 16'h0000;
  endtask

  // Test sequence.
  initial begin
    test_reset();
    test_sched_en();
    test_single_read();
    test_wrap();
    test_rd_limit();
    test_stall();
    test_retire_collision();
    test_wr_prio();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb2axi_issue_sched.md
Name: apb2axi_issue_sched

Overview:
- Scheduler between the request directory and the AXI AR/AW issue stage.
- Each cycle it takes the mask of directory entries in PENDING state and picks one tag round-robin, subject to per-direction outstanding limits.
- It offers the chosen tag to the issue stage with a valid/ready handshake and tracks read and write transactions in flight until the response handler retires them.

Parameters:
- NUM_TAGS, 16, number of directory entries; TAG_W = $clog2(NUM_TAGS).
- MAX_RD_OUTST, 4, maximum reads issued and not yet retired (1..15).
- MAX_WR_OUTST, 4, maximum writes issued and not yet retired (1..15).

Ports:
- pclk, input, 1, clock; single clock domain.
- preset, input, 1, reset; synchronous, active-high.
- sched_en, input, 1, when 0 no new grant is made; an offer already in progress still completes.
- pend_mask, input, NUM_TAGS, bit t=1 means directory entry t is PENDING.
- pend_is_write, input, NUM_TAGS, direction per entry; 1 = write.
- issue_valid, output, 1, tag offered to the issue stage.
- issue_ready, input, 1, issue stage accepts the offer.
- issue_tag, output, TAG_W, offered tag.
- issue_is_write, output, 1, direction of the offered tag.
- issued_pulse, output, 1, one-cycle pulse on handshake; the directory moves issued_tag to ISSUED.
- issued_tag, output, TAG_W, tag that was accepted.
- rd_retire, input, 1, one read completed (from the response handler).
- wr_retire, input, 1, one write completed.
- rd_outst, output, 4, current read count.
- wr_outst, output, 4, current write count.
- cnt_err, output, 1, sticky; set when a retire arrives while the matching count is 0.
- busy, output, 1, high while FSM ≠ S_IDLE or rd_outst+wr_outst ≠ 0.

Behaviour:
- Reset values: all outputs 0; FSM = S_IDLE; rr_ptr = 0; counters = 0; cnt_err cleared; last_tag_mask = 0.
- Eligibility: tag t is eligible when all of the following hold:
  - pend_mask[t] = 1;
  - last_tag_mask[t] = 0;
  - pend_is_write[t] ? (wr_outst < MAX_WR_OUTST) : (rd_outst < MAX_RD_OUTST).
- Round-robin selection: scan from rr_ptr upward, wrapping from NUM_TAGS-1 to 0. The first eligible tag wins.
- FSM, two states:
  - S_IDLE: if sched_en and any tag is eligible, register the winner into issue_tag / issue_is_write, set issue_valid=1, go to S_OFFER. Otherwise stay.
  - S_OFFER: issue_valid, issue_tag and issue_is_write are held stable until issue_ready. Changes to pend_mask do not affect the offer.
  - S_OFFER handshake cycle (issue_valid & issue_ready): on the next edge, issue_valid=0, issued_pulse=1, issued_tag=issue_tag, rr_ptr=(issue_tag+1) mod NUM_TAGS, and the matching counter is incremented. Then go to S_IDLE.
- Latency:
  - An eligible pend_mask bit at cycle N produces issue_valid at cycle N+1.
  - Back-to-back grants run at most one per 2 cycles.
- last_tag_mask: set to the one-hot issued_tag for exactly the one cycle after the handshake, then cleared. This masks the directory's one-cycle lag in dropping pend_mask.
- Counters:
  - Retire and issue of the same direction in the same cycle leave the count unchanged.
  - rd_retire and wr_retire may be asserted in the same cycle; each affects only its own counter.
  - A retire when the count is 0 saturates the count at 0 and sets cnt_err.
  - Counts never exceed MAX_*_OUTST, because eligibility blocks further issue.
- sched_en deasserted in S_OFFER does not withdraw issue_valid.
- preset mid-offer drops issue_valid on the next edge with no issued_pulse. Counters are cleared even if transactions are still outstanding.

Optional Feature:
- Macro: APB2AXI_SCHED_WR_PRIO_EN.
- Defined: if any write tag is eligible, only write tags are considered, round-robin among writes. Reads are granted only when no write is eligible.
- Undefined: a single round-robin runs over all eligible tags regardless of direction.

Test Plan:
- Reset, then pend_mask=0x0004 (read) with issue_ready=1 -> issue_valid at N+1 with tag 2, issued_pulse the next cycle, rd_outst=1, rr_ptr=3.
- pend_mask=0x8001, all reads, ready always 1 -> grants in order 0, 15, then 0 again (mask held), confirming rr_ptr wrap from 15 to 0.
- Five read tags pending, no retires -> exactly 4 grants and rd_outst=4. One rd_retire -> 5th grant issued next, and rd_outst returns to 4.
- issue_ready held 0 for 6 cycles while pend_mask and sched_en toggle -> issue_valid and issue_tag stay stable; a single issued_pulse follows when ready rises.
- rd_retire with issue handshake (read) in the same cycle -> rd_outst unchanged. Then wr_retire with wr_outst=0 -> cnt_err=1 and sticky, wr_outst stays 0.
- Tags 1 (read) and 2 (write) both pending, rr_ptr=0 -> tag 1 first without the macro, tag 2 first with APB2AXI_SCHED_WR_PRIO_EN.
